part2: RTL and testbench
========================

Name: part2

Overview:
- Registered WIDTH-bit ripple-carry adder. Default WIDTH is 4.
- Computes s = a + b + cin through a chain of 1-bit full-adder cells. The carry ripples from the LSB cell to the MSB cell.
- Sum, carry-out and signed-overflow are captured in output registers.
- Used as the basic integer add stage in the datapath. One result per clock when in_valid is held high.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  when high, the operands on a, b and cin are sampled on this clk edge.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in into bit 0.
- s  output  WIDTH  registered sum bits, (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB cell.
- ovf  output  1  registered signed overflow: carry into the MSB cell XOR cout.
- out_valid  output  1  high for one cycle after each accepted in_valid.

Behaviour:
- Full-adder cell, bit i:
  - s_i = a_i ^ b_i ^ c_i.
  - c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)).
  - c_0 = cin.
  - Instantiate WIDTH cells in a chain. No carry-lookahead; the combinational path is the full ripple.
- Arithmetic:
  - {cout, s} equals the (WIDTH+1)-bit sum of a, b and cin.
  - ovf = c_{WIDTH-1} ^ c_WIDTH. This is the two's-complement overflow.
- Latency: 1 cycle. If in_valid is high at edge N, the result of those inputs appears on s, cout and ovf after edge N, and out_valid is high after edge N.
- out_valid:
  - Follows in_valid registered, with no back-pressure.
  - Consecutive in_valid cycles give consecutive results, one per cycle.
- Hold: when in_valid is low at an edge, s, cout and ovf keep their previous values, and out_valid goes low.
- Reset:
  - rst high clears s, cout, ovf and out_valid to 0 immediately, without waiting for clk.
  - While rst is high, edges are ignored.
  - Reset asserted mid-operation discards any in-flight result.
  - After rst deasserts, the first edge with in_valid high produces a normal result.
- Wrap-around:
  - The maximal case a = b = 2^WIDTH-1 with cin = 1 gives s = 2^WIDTH-1 and cout = 1.
  - a = b = 0 with cin = 0 gives all outputs 0.
- X or unknown inputs: no requirement while in_valid is low.

Test Plan:
- Basic vectors at WIDTH=4, in_valid=1, one vector per cycle, each checked one cycle later:
  - a=3, b=4, cin=0 -> s=7, cout=0, ovf=0.
  - a=7, b=E, cin=0 -> s=5, cout=1, ovf=0.
  - a=9, b=8, cin=1 -> s=2, cout=1, ovf=1.
  - a=A, b=F, cin=1 -> s=A, cout=1, ovf=0.
  - a=E, b=1, cin=0 -> s=F, cout=0, ovf=0.
- Carry chain: a=F, b=0, cin=1 -> s=0, cout=1, ovf=0. Then a=F, b=F, cin=1 -> s=F, cout=1, ovf=0.
- Signed overflow: a=7, b=1, cin=0 -> s=8, cout=0, ovf=1. Then a=8, b=8, cin=0 -> s=0, cout=1, ovf=1.
- Hold and valid:
  - Apply in_valid=1 with a=3, b=4, cin=0 for one cycle.
  - Then hold in_valid=0 while changing a, b and cin.
  - Required: s stays 7 and out_valid is high for exactly one cycle.
- Async reset:
  - Load a=A, b=F, cin=1 so that s=A.
  - Assert rst between clock edges.
  - Required: s, cout, ovf and out_valid go to 0 before the next edge.
  - After release, the next valid vector produces the correct result.
- Exhaustive: all 512 combinations of a, b and cin at WIDTH=4, streamed back-to-back, compared against a behavioural (WIDTH+1)-bit sum with ovf.

Source files
------------

// File: rtl/part2.sv
// Registered ripple-carry adder: WIDTH full-adder cells chained LSB to MSB,
// with sum, carry-out and two's-complement overflow captured in output registers.

module part2_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_p;

  assign w_p = i_a ^ i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module part2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    part2_fa u_fa (
      .i_a (a[i]),
      .i_b (b[i]),
      .i_c (w_carry[i]),
      .o_s (w_sum[i]),
      .o_c (w_carry[i+1])
    );
  end

  // Result registers hold their value on idle cycles; only out_valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_sum;
        r_cout <= w_carry[WIDTH];
        r_ovf  <= w_carry[WIDTH-1] ^ w_carry[WIDTH];
      end
    end
  end

  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;
endmodule

// File: tb/tb_part2.sv
// Directed and exhaustive checks for the 4-bit registered ripple-carry adder.

module tb_part2;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         out_valid;

  int checks;
  int errors;

  part2 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [W-1:0] es,
                           input logic ec, input logic eo, input logic ev);
    check({name, ".s"}, int'(s), int'(es));
    check({name, ".cout"}, int'(cout), int'(ec));
    check({name, ".ovf"}, int'(ovf), int'(eo));
    check({name, ".out_valid"}, int'(out_valid), int'(ev));
  endtask

  // Drive on the falling edge, sample 1 time unit after the following rising edge.
  task automatic apply(input logic v, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic vc);
    @(negedge clk);
    in_valid = v;
    a = va;
    b = vb;
    cin = vc;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[9];

  initial begin
    logic [W:0]   full;
    logic [W-1:0] es;
    logic         eo;

    checks = 0;
    errors = 0;

    vecs[0] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0};
    vecs[1] = '{4'h7, 4'hE, 1'b0, 4'h5, 1'b1, 1'b0};
    vecs[2] = '{4'h9, 4'h8, 1'b1, 4'h2, 1'b1, 1'b1};
    vecs[3] = '{4'hA, 4'hF, 1'b1, 4'hA, 1'b1, 1'b0};
    vecs[4] = '{4'hE, 4'h1, 1'b0, 4'hF, 1'b0, 1'b0};
    vecs[5] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[6] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[7] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
    vecs[8] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #12;
    check_all("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Zero operands give all-zero outputs with out_valid high.
    apply(1'b1, 4'h0, 4'h0, 1'b0);
    check_all("zero", 4'h0, 1'b0, 1'b0, 1'b1);

    // Table vectors streamed back-to-back.
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      check_all($sformatf("vec%0d", i), vecs[i].s, vecs[i].cout, vecs[i].ovf, 1'b1);
    end

    // Hold: one valid vector, then idle cycles with changing operands.
    apply(1'b1, 4'h3, 4'h4, 1'b0);
    check_all("hold_load", 4'h7, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 4'hF, 4'hF, 1'b1);
    check_all("hold1", 4'h7, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'h9, 4'h8, 1'b1);
    check_all("hold2", 4'h7, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 4'h1, 4'h2, 1'b0);
    check_all("hold3", 4'h7, 1'b0, 1'b0, 1'b0);

    // Async reset mid-cycle, then held across an edge with valid input.
    apply(1'b1, 4'hA, 4'hF, 1'b1);
    check_all("pre_rst", 4'hA, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'h9;
    b = 4'h8;
    cin = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_held", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    apply(1'b1, 4'h7, 4'hE, 1'b0);
    check_all("post_rst", 4'h5, 1'b1, 1'b0, 1'b1);

    // Exhaustive stream against a behavioural (W+1)-bit sum.
    for (int k = 0; k < 512; k++) begin
      logic [W-1:0] ka;
      logic [W-1:0] kb;
      logic         kc;
      ka = k[3:0];
      kb = k[7:4];
      kc = k[8];
      full = {1'b0, ka} + {1'b0, kb} + {{W{1'b0}}, kc};
      es = full[W-1:0];
      eo = (ka[W-1] == kb[W-1]) && (es[W-1] != ka[W-1]);
      apply(1'b1, ka, kb, kc);
      check_all($sformatf("exh%0d", k), es, full[W], eo, 1'b1);
    end

    apply(1'b0, 4'h0, 4'h0, 1'b0);
    check("final_idle.out_valid", int'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
